// File: rtl/reg_bus_ctrl.sv
// rtl/reg_bus_ctrl.sv - register bus controller: command -> one-cycle register access -> response
// Optional write acknowledge: define REG_BUS_CTRL_WRITE_ACK_EN to return a response for writes.
module reg_bus_ctrl #(
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wr,
  input  logic [AW-1:0]   req_addr,
  input  logic [15:0]     req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [15:0]     resp_rdata,
  output logic            wr,
  output logic [NREG-1:0] sel,
  output logic [15:0]     wdata,
  input  logic [15:0]     rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  logic   lat_wr;

  // Commands are only taken while idle; everything else back-pressures upstream.
  assign req_ready = (state == IDLE);

  // Transaction FSM; register bus strobes and response are all registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat_wr     <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 16'h0000;
      sel        <= '0;
      wr         <= 1'b0;
      wdata      <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_wr <= req_wr;
            sel    <= NREG'(1) << req_addr;
            wr     <= req_wr;
            wdata  <= req_wdata;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          // Strobes are single-cycle; wdata keeps its value for observability.
          sel <= '0;
          wr  <= 1'b0;
          if (!lat_wr) begin
            resp_rdata <= rdata;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
`ifdef REG_BUS_CTRL_WRITE_ACK_EN
            resp_rdata <= 16'h0000;
            resp_valid <= 1'b1;
            state      <= RESP;
`else
            state      <= IDLE;
`endif
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_ctrl.sv
// tb/tb_reg_bus_ctrl.sv - self-checking bench for reg_bus_ctrl (honours REG_BUS_CTRL_WRITE_ACK_EN)
module tb_reg_bus_ctrl;

  localparam int NREG = 4;
  localparam int AW   = 2;
`ifdef REG_BUS_CTRL_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic            req_wr;
  logic [AW-1:0]   req_addr;
  logic [15:0]     req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [15:0]     resp_rdata;
  logic            wr;
  logic [NREG-1:0] sel;
  logic [15:0]     wdata;
  logic [15:0]     rdata;

  reg_bus_ctrl #(.NREG(NREG), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .wr         (wr),
    .sel        (sel),
    .wdata      (wdata),
    .rdata      (rdata)
  );

  always #5 clk = ~clk;

  // Register file sitting on the shared bus: selected registers capture on wr.
  logic [15:0] regs [NREG];
  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (rst) regs[i] <= 16'h0000;
      else if (wr && sel[i]) regs[i] <= wdata;
    end
  end

  // Unselected registers drive zero; the bus is the OR of all read ports.
  always_comb begin
    rdata = 16'h0000;
    for (int i = 0; i < NREG; i++) begin
      if (sel[i]) rdata = rdata | regs[i];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] mem [NREG];

  typedef struct {
    bit          w;
    int          addr;
    logic [15:0] wd;
    bit          exp_resp;
    logic [15:0] exp_rd;
    int          hold;
  } vec_t;

  vec_t vec [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < NREG; i++) mem[i] = 16'h0000;
  endtask

  // One complete command: acceptance, access cycle, optional response with back-pressure.
  task automatic do_cmd(input bit w, input int a, input logic [15:0] d, input bit er,
                        input logic [15:0] ed, input int hold, input string tag);
    req_valid  = 1'b1;
    req_wr     = w;
    req_addr   = AW'(a);
    req_wdata  = d;
    resp_ready = (hold == 0);
    check({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_wdata = 16'h0000;
    check({tag, "_acc_sel"}, 32'(sel), 32'(1 << a));
    check({tag, "_acc_wr"}, 32'(wr), 32'(w));
    check({tag, "_acc_wdata"}, 32'(wdata), 32'(d));
    check({tag, "_acc_rv"}, 32'(resp_valid), 32'd0);
    check({tag, "_acc_ready"}, 32'(req_ready), 32'd0);
    if (w) mem[a] = d;
    tick();
    check({tag, "_post_sel"}, 32'(sel), 32'd0);
    check({tag, "_post_wr"}, 32'(wr), 32'd0);
    check({tag, "_post_wdata"}, 32'(wdata), 32'(d));
    if (er) begin
      for (int k = 0; k < hold; k++) begin
        check({tag, "_hold_rv"}, 32'(resp_valid), 32'd1);
        check({tag, "_hold_rdata"}, 32'(resp_rdata), 32'(ed));
        check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
        tick();
      end
      resp_ready = 1'b1;
      check({tag, "_resp_rv"}, 32'(resp_valid), 32'd1);
      check({tag, "_resp_rdata"}, 32'(resp_rdata), 32'(ed));
      check({tag, "_resp_ready"}, 32'(req_ready), 32'd0);
      tick();
    end
    check({tag, "_done_rv"}, 32'(resp_valid), 32'd0);
    check({tag, "_done_ready"}, 32'(req_ready), 32'd1);
  endtask

  // Rst during the access cycle of a read: no response, outputs back to reset values.
  task automatic abort_in_access(input int a);
    req_valid  = 1'b1;
    req_wr     = 1'b0;
    req_addr   = AW'(a);
    req_wdata  = 16'h5A5A;
    resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    check("abort_acc_sel", 32'(sel), 32'(1 << a));
    check("abort_acc_wdata", 32'(wdata), 32'h5A5A);
    rst = 1'b1;
    tick();
    check("abort_acc_rv", 32'(resp_valid), 32'd0);
    check("abort_acc_rdata", 32'(resp_rdata), 32'd0);
    check("abort_acc_sel0", 32'(sel), 32'd0);
    check("abort_acc_wr0", 32'(wr), 32'd0);
    check("abort_acc_wdata0", 32'(wdata), 32'd0);
    rst = 1'b0;
    clear_mem();
    tick();
    check("abort_acc_ready_after", 32'(req_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      check("abort_acc_no_rv", 32'(resp_valid), 32'd0);
      tick();
    end
  endtask

  // Rst while a response is waiting: the response is dropped.
  task automatic abort_in_resp(input int a, input logic [15:0] ed);
    req_valid  = 1'b1;
    req_wr     = 1'b0;
    req_addr   = AW'(a);
    resp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    check("abort_resp_rv_pre", 32'(resp_valid), 32'd1);
    check("abort_resp_rdata_pre", 32'(resp_rdata), 32'(ed));
    rst = 1'b1;
    tick();
    check("abort_resp_rv", 32'(resp_valid), 32'd0);
    check("abort_resp_rdata", 32'(resp_rdata), 32'd0);
    rst = 1'b0;
    clear_mem();
    tick();
    check("abort_resp_ready_after", 32'(req_ready), 32'd1);
    check("abort_resp_no_rv", 32'(resp_valid), 32'd0);
    resp_ready = 1'b1;
  endtask

  // Transaction-timeline reference: each accepted command occupies the bus one cycle later,
  // answers two cycles after acceptance, and frees the port the cycle after the handshake.
  task automatic run_random(input int ncyc, input bit hold_valid, input bit always_ready,
                            input bit rd_only, input string tag, output int dut_acc);
    int          next_free;
    int          acc_c;
    bit          acc_wr;
    int          acc_addr;
    logic [15:0] acc_data;
    bit          resp_open;
    int          resp_c;
    logic [15:0] resp_val;
    bit          exp_ready;
    bit          exp_access;
    bit          exp_rv;
    next_free = 0;
    acc_c     = -10;
    acc_wr    = 1'b0;
    acc_addr  = 0;
    acc_data  = 16'h0000;
    resp_open = 1'b0;
    resp_c    = 0;
    resp_val  = 16'h0000;
    dut_acc   = 0;
    for (int c = 0; c < ncyc; c++) begin
      exp_ready  = !resp_open && (c >= next_free);
      exp_access = (c == acc_c + 1);
      exp_rv     = resp_open && (c >= resp_c);
      check({tag, "_req_ready"}, 32'(req_ready), 32'(exp_ready));
      check({tag, "_sel"}, 32'(sel), exp_access ? 32'(1 << acc_addr) : 32'd0);
      check({tag, "_wr"}, 32'(wr), 32'(exp_access && acc_wr));
      check({tag, "_sel_onehot"}, 32'($countones(sel) <= 1), 32'd1);
      if (exp_access) check({tag, "_wdata"}, 32'(wdata), 32'(acc_data));
      check({tag, "_resp_valid"}, 32'(resp_valid), 32'(exp_rv));
      if (exp_rv) check({tag, "_resp_rdata"}, 32'(resp_rdata), 32'(resp_val));

      req_valid  = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
      req_wr     = rd_only ? 1'b0 : 1'($urandom_range(0, 1));
      req_addr   = AW'($urandom_range(0, NREG - 1));
      req_wdata  = 16'($urandom);
      resp_ready = always_ready ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (req_valid && req_ready) dut_acc++;

      if (exp_rv && resp_ready) begin
        resp_open = 1'b0;
        next_free = c + 1;
      end
      if (req_valid && exp_ready) begin
        acc_c    = c;
        acc_wr   = req_wr;
        acc_addr = int'(req_addr);
        acc_data = req_wdata;
        if (req_wr) mem[acc_addr] = req_wdata;
        if (!req_wr || ACK) begin
          resp_open = 1'b1;
          resp_c    = c + 2;
          resp_val  = req_wr ? 16'h0000 : mem[acc_addr];
        end else begin
          next_free = c + 2;
        end
      end
      tick();
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check({tag, "_drained_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int acc;
    vec[0]  = '{1'b1, 2, 16'hBEEF, ACK,  16'h0000, 0};
    vec[1]  = '{1'b0, 2, 16'h0000, 1'b1, 16'hBEEF, 0};
    vec[2]  = '{1'b1, 0, 16'h1111, ACK,  16'h0000, 0};
    vec[3]  = '{1'b1, 1, 16'h2222, ACK,  16'h0000, 0};
    vec[4]  = '{1'b1, 2, 16'h3333, ACK,  16'h0000, 0};
    vec[5]  = '{1'b1, 3, 16'h4444, ACK,  16'h0000, 0};
    vec[6]  = '{1'b0, 3, 16'h0000, 1'b1, 16'h4444, 0};
    vec[7]  = '{1'b0, 0, 16'h0000, 1'b1, 16'h1111, 0};
    vec[8]  = '{1'b0, 2, 16'h0000, 1'b1, 16'h3333, 0};
    vec[9]  = '{1'b0, 1, 16'h0000, 1'b1, 16'h2222, 0};
    vec[10] = '{1'b0, 1, 16'h0000, 1'b1, 16'h2222, 5};
    vec[11] = '{1'b1, 1, 16'hABCD, ACK,  16'h0000, 2};
    vec[12] = '{1'b0, 1, 16'h0000, 1'b1, 16'hABCD, 1};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_wr     = 1'b0;
    req_addr   = '0;
    req_wdata  = 16'h0000;
    resp_ready = 1'b0;
    clear_mem();
    tick();
    tick();
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_rdata", 32'(resp_rdata), 32'd0);
    check("reset_sel", 32'(sel), 32'd0);
    check("reset_wr", 32'(wr), 32'd0);
    check("reset_wdata", 32'(wdata), 32'd0);
    rst = 1'b0;
    tick();
    check("reset_release_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < $size(vec); i++) begin
      do_cmd(vec[i].w, vec[i].addr, vec[i].wd, vec[i].exp_resp, vec[i].exp_rd,
             vec[i].hold, $sformatf("vec%0d", i));
    end

    abort_in_access(2);
    do_cmd(1'b1, 3, 16'h7777, ACK, 16'h0000, 0, "pre_abort_wr");
    abort_in_resp(3, 16'h7777);

    run_random(30, 1'b1, 1'b1, 1'b1, "stream_rd", acc);
    check("stream_rd_accept_count", 32'(acc), 32'd10);
    run_random(300, 1'b1, 1'b1, 1'b0, "stream_mix", acc);
    run_random(600, 1'b0, 1'b0, 1'b0, "rand_mix", acc);

    for (int i = 0; i < NREG; i++) begin
      do_cmd(1'b0, i, 16'h0000, 1'b1, mem[i], 0, $sformatf("final_rd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
